// File: rtl/pdc_fill_ctrl.sv
// Purpose : write-side feeder for the 2048-entry predecode cache RAM; buffers two
//           predecoded lines, serialises each line into 4 entry writes, and runs a
//           full-array invalidation sweep. Also flags reads that target stale lines.
// Latency : line accepted at edge T into an idle, empty buffer -> RAM writes in
//           cycles T+1..T+4; sustained 1 line per 4 cycles with no bubbles.
// Backpr. : fill_ready drops when both buffer slots hold lines, while an invalidate
//           is pending, or during the sweep; upstream holds the offered line.
// Ports   : clk/rst (sync, active-high); fill_valid/fill_ready/fill_line/fill_data
//           line input; inv_req/inv_done sweep request and completion pulse;
//           write_addr/write_data/write_wen RAM write port; read_addr/read_clkEn
//           monitored read ports; rd_hazard per-port replay flag; busy.
module pdc_fill_ctrl #(
    parameter int PDC_W    = 40,
    parameter int LINE_ENT = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      fill_valid,
    output logic                      fill_ready,
    input  logic [8:0]                fill_line,
    input  logic [LINE_ENT*PDC_W-1:0] fill_data,
    input  logic                      inv_req,
    output logic                      inv_done,
    output logic [10:0]               write_addr,
    output logic [PDC_W-1:0]          write_data,
    output logic                      write_wen,
    input  logic [2:0][10:0]          read_addr,
    input  logic [2:0]                read_clkEn,
    output logic [2:0]                rd_hazard,
    output logic                      busy
);

    typedef enum logic [1:0] {IDLE, FILL, INV} state_t;

    state_t                    state;
    logic [8:0]                ent_line [2];
    logic [LINE_ENT*PDC_W-1:0] ent_data [2];
    logic [1:0]                ent_vld;
    logic                      wr_ptr;
    logic                      rd_ptr;
    logic [1:0]                beat;
    logic                      inv_pend;
    logic [11:0]               sweep_cnt;
    logic                      wen_q;
    logic                      done_q;

    logic                      full;
    logic                      head_vld;
    logic                      push;
    logic                      pop;
    logic [PDC_W-1:0]          head_ent [LINE_ENT];

    assign full       = &ent_vld;
    assign head_vld   = ent_vld[rd_ptr];
    assign fill_ready = !rst && !full && !inv_pend && (state != INV);
    assign push       = fill_valid && fill_ready;
    // Head leaves the buffer on the same edge its last beat is registered out.
    assign pop        = head_vld && (state != INV) && (beat == 2'd3);

    always_comb begin
        for (int i = 0; i < LINE_ENT; i++) begin
            head_ent[i] = ent_data[rd_ptr][i*PDC_W +: PDC_W];
        end
    end

    // Line storage needs no reset: occupancy is tracked solely by ent_vld.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_line[wr_ptr] <= fill_line;
            ent_data[wr_ptr] <= fill_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ent_vld    <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            state      <= IDLE;
            beat       <= 2'd0;
            inv_pend   <= 1'b0;
            sweep_cnt  <= '0;
            wen_q      <= 1'b0;
            write_addr <= '0;
            write_data <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // push and pop never touch the same slot: push needs a free slot,
            // pop needs the head slot occupied.
            if (push) begin
                ent_vld[wr_ptr] <= 1'b1;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                ent_vld[rd_ptr] <= 1'b0;
                rd_ptr          <= ~rd_ptr;
            end
            if (inv_req && (state != INV)) begin
                inv_pend <= 1'b1;
            end
            case (state)
                IDLE, FILL: begin
                    // Buffered lines always drain ahead of a pending sweep.
                    if (head_vld) begin
                        state      <= FILL;
                        wen_q      <= 1'b1;
                        write_addr <= {ent_line[rd_ptr], beat};
                        write_data <= head_ent[beat];
                        beat       <= beat + 2'd1;
                    end else if (inv_pend) begin
                        state      <= INV;
                        wen_q      <= 1'b1;
                        write_addr <= '0;
                        write_data <= '0;
                        sweep_cnt  <= '0;
                    end else begin
                        state <= IDLE;
                        wen_q <= 1'b0;
                    end
                end
                INV: begin
                    if (sweep_cnt == 12'd2047) begin
                        state     <= IDLE;
                        wen_q     <= 1'b0;
                        inv_pend  <= 1'b0;
                        done_q    <= 1'b1;
                        sweep_cnt <= '0;
                    end else begin
                        sweep_cnt  <= sweep_cnt + 12'd1;
                        write_addr <= sweep_cnt[10:0] + 11'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A write registered before reset must not reach the RAM during reset.
    assign write_wen = wen_q && !rst;
    assign inv_done  = done_q && !rst;
    assign busy      = (|ent_vld) || (state != IDLE) || inv_pend;

    always_comb begin
        rd_hazard = '0;
        for (int k = 0; k < 3; k++) begin
            rd_hazard[k] = read_clkEn[k] &&
                           ((state == INV) || inv_pend ||
                            (ent_vld[0] && (read_addr[k][10:2] == ent_line[0])) ||
                            (ent_vld[1] && (read_addr[k][10:2] == ent_line[1])));
        end
    end

    // Entry-select bits of the read addresses do not affect line matching.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, read_addr[0][1:0], read_addr[1][1:0], read_addr[2][1:0]};

endmodule

// File: tb/tb_pdc_fill_ctrl.sv
// Purpose : directed self-checking bench for pdc_fill_ctrl.
// Latency : stimulus driven 1 time unit after each rising edge, outputs checked there.
// Backpr. : fills are offered with fill_valid held until fill_ready is seen.
module tb_pdc_fill_ctrl;
    localparam int PDC_W = 40;

    logic             clk = 1'b0;
    logic             rst;
    logic             fill_valid;
    logic             fill_ready;
    logic [8:0]       fill_line;
    logic [4*PDC_W-1:0] fill_data;
    logic             inv_req;
    logic             inv_done;
    logic [10:0]      write_addr;
    logic [PDC_W-1:0] write_data;
    logic             write_wen;
    logic [2:0][10:0] read_addr;
    logic [2:0]       read_clkEn;
    logic [2:0]       rd_hazard;
    logic             busy;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pdc_fill_ctrl #(.PDC_W(PDC_W), .LINE_ENT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .fill_valid (fill_valid),
        .fill_ready (fill_ready),
        .fill_line  (fill_line),
        .fill_data  (fill_data),
        .inv_req    (inv_req),
        .inv_done   (inv_done),
        .write_addr (write_addr),
        .write_data (write_data),
        .write_wen  (write_wen),
        .read_addr  (read_addr),
        .read_clkEn (read_clkEn),
        .rd_hazard  (rd_hazard),
        .busy       (busy)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entry data pattern: {line, 4'h0} + beat + 1, unique per address.
    function automatic logic [PDC_W-1:0] fdat(input logic [10:0] a);
        logic [PDC_W-1:0] r;
        r = '0;
        r[12:0] = {a[10:2], 4'h0};
        r = r + {38'd0, a[1:0]} + 40'd1;
        return r;
    endfunction

    function automatic logic [4*PDC_W-1:0] mk_line(input logic [8:0] line);
        logic [4*PDC_W-1:0] d;
        logic [1:0] bb;
        d = '0;
        for (int b = 0; b < 4; b++) begin
            bb = b[1:0];
            d[b*PDC_W +: PDC_W] = fdat({line, bb});
        end
        return d;
    endfunction

    // Runs through pre_n leftover fill writes starting at pre_addr, then the sweep.
    task automatic sweep_run(input string nm, input logic [10:0] pre_addr, input int pre_n,
                             input int reinv_at, input int n_steps);
        int w = 0;
        int pulses = 0;
        int bad_wr = 0;
        int bad_rdy = 0;
        int bad_haz = 0;
        int done_ok = 0;
        logic prev_wen = 1'b0;
        logic [10:0] prev_addr = '0;
        logic [10:0] ea;
        logic [PDC_W-1:0] ed;
        for (int c = 0; c < n_steps; c++) begin
            if (c > 0) begin
                fill_valid = 1'b0;
                inv_req = (reinv_at >= 0) && (w == reinv_at);
            end
            step();
            if (write_wen) begin
                if (w < pre_n) begin
                    ea = pre_addr + 11'(w);
                    ed = fdat(ea);
                end else begin
                    ea = 11'(w - pre_n);
                    ed = '0;
                end
                if (write_addr !== ea || write_data !== ed) bad_wr++;
                if (fill_ready !== 1'b0) bad_rdy++;
                if (rd_hazard !== read_clkEn) bad_haz++;
                w++;
            end
            if (inv_done) begin
                pulses++;
                if (prev_wen && prev_addr == 11'd2047 && !write_wen) done_ok = 1;
            end
            prev_wen = write_wen;
            prev_addr = write_addr;
        end
        inv_req = 1'b0;
        check_val({nm, "_write_count"}, 64'(w), 64'(pre_n + 2048));
        check_val({nm, "_write_errs"}, 64'(bad_wr), 64'd0);
        check_val({nm, "_ready_errs"}, 64'(bad_rdy), 64'd0);
        check_val({nm, "_hazard_errs"}, 64'(bad_haz), 64'd0);
        check_val({nm, "_done_pulses"}, 64'(pulses), 64'd1);
        check_val({nm, "_done_after_last"}, 64'(done_ok), 64'd1);
        check_val({nm, "_busy_end"}, 64'(busy), 64'd0);
        check_val({nm, "_ready_end"}, 64'(fill_ready), 64'd1);
    endtask

    initial begin
        int idx;
        int nw;
        int gap;
        int bad;
        int found;
        int wcnt;
        int dcnt;
        logic acc;
        logic [8:0] lines [3];

        rst = 1'b1;
        fill_valid = 1'b0;
        fill_line = '0;
        fill_data = '0;
        inv_req = 1'b0;
        read_addr = '0;
        read_clkEn = 3'b000;

        // Reset state
        step();
        step();
        check_val("rst_wen", 64'(write_wen), 64'd0);
        check_val("rst_addr", 64'(write_addr), 64'd0);
        check_val("rst_data", 64'(write_data), 64'd0);
        check_val("rst_done", 64'(inv_done), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_hazard", 64'(rd_hazard), 64'd0);
        check_val("rst_ready", 64'(fill_ready), 64'd0);
        rst = 1'b0;
        #1;
        check_val("ready_after_rst", 64'(fill_ready), 64'd1);

        // Single fill, line 0x005, entries 1..4
        fill_valid = 1'b1;
        fill_line = 9'h005;
        fill_data = {40'd4, 40'd3, 40'd2, 40'd1};
        step();
        fill_valid = 1'b0;
        check_val("single_no_write_at_T", 64'(write_wen), 64'd0);
        for (int b = 0; b < 4; b++) begin
            step();
            check_val("single_wen", 64'(write_wen), 64'd1);
            check_val("single_addr", 64'(write_addr), 64'(11'h014 + b));
            check_val("single_data", 64'(write_data), 64'(b + 1));
        end
        step();
        check_val("single_wen_end", 64'(write_wen), 64'd0);
        check_val("single_busy_end", 64'(busy), 64'd0);

        // Back-to-back fills of lines 1,2,3
        lines[0] = 9'h001;
        lines[1] = 9'h002;
        lines[2] = 9'h003;
        idx = 0;
        nw = 0;
        gap = 0;
        bad = 0;
        fill_valid = 1'b1;
        fill_line = lines[0];
        fill_data = mk_line(lines[0]);
        for (int c = 0; c < 20; c++) begin
            acc = fill_valid && fill_ready;
            step();
            if (acc) begin
                idx++;
                if (idx == 2) check_val("b2b_ready_after_2nd", 64'(fill_ready), 64'd0);
                if (idx < 3) begin
                    fill_line = lines[idx];
                    fill_data = mk_line(lines[idx]);
                end else begin
                    fill_valid = 1'b0;
                end
            end
            if (write_wen) begin
                if (write_addr !== 11'(4 + nw) || write_data !== fdat(11'(4 + nw))) bad++;
                nw++;
                if (nw == 4) check_val("b2b_ready_after_pop", 64'(fill_ready), 64'd1);
            end else if (nw > 0 && nw < 12) begin
                gap++;
            end
        end
        fill_valid = 1'b0;
        check_val("b2b_accepts", 64'(idx), 64'd3);
        check_val("b2b_write_count", 64'(nw), 64'd12);
        check_val("b2b_gaps", 64'(gap), 64'd0);
        check_val("b2b_write_errs", 64'(bad), 64'd0);

        // Hazard on queued line 0x010
        read_addr[0] = 11'h040;
        read_addr[1] = 11'h041;
        read_addr[2] = 11'h041;
        read_clkEn = 3'b010;
        check_val("haz_idle", 64'(rd_hazard), 64'd0);
        fill_valid = 1'b1;
        fill_line = 9'h010;
        fill_data = mk_line(9'h010);
        step();
        fill_valid = 1'b0;
        check_val("haz_queued", 64'(rd_hazard), 64'b010);
        for (int b = 0; b < 4; b++) begin
            step();
            check_val("haz_port1", 64'(rd_hazard[1]), (b < 3) ? 64'd1 : 64'd0);
            check_val("haz_port0_disabled", 64'(rd_hazard[0]), 64'd0);
        end
        step();

        // Invalidate during line 0x0FF
        read_clkEn = 3'b111;
        fill_valid = 1'b1;
        fill_line = 9'h0FF;
        fill_data = mk_line(9'h0FF);
        step();
        fill_valid = 1'b0;
        step();
        step();
        check_val("inv_beat1_addr", 64'(write_addr), 64'h3FD);
        inv_req = 1'b1;
        sweep_run("inv_inflight", 11'h3FE, 2, -1, 2200);
        read_clkEn = 3'b000;

        // Simultaneous inv_req and fill accept, second inv_req mid-sweep
        fill_valid = 1'b1;
        fill_line = 9'h0A0;
        fill_data = mk_line(9'h0A0);
        inv_req = 1'b1;
        check_val("simul_ready", 64'(fill_ready), 64'd1);
        sweep_run("inv_simul", 11'h280, 4, 500, 2200);

        // Reset during the sweep at address 100
        inv_req = 1'b1;
        step();
        inv_req = 1'b0;
        found = 0;
        for (int c = 0; c < 300; c++) begin
            step();
            if (write_wen && write_addr == 11'd100) begin
                found = 1;
                break;
            end
        end
        check_val("rstsweep_reached_100", 64'(found), 64'd1);
        rst = 1'b1;
        #1;
        check_val("rstsweep_wen_rst_cycle", 64'(write_wen), 64'd0);
        step();
        check_val("rstsweep_wen", 64'(write_wen), 64'd0);
        check_val("rstsweep_done", 64'(inv_done), 64'd0);
        check_val("rstsweep_busy", 64'(busy), 64'd0);
        check_val("rstsweep_ready_in_rst", 64'(fill_ready), 64'd0);
        rst = 1'b0;
        #1;
        check_val("rstsweep_ready_after", 64'(fill_ready), 64'd1);
        wcnt = 0;
        dcnt = 0;
        for (int c = 0; c < 2100; c++) begin
            step();
            if (write_wen) wcnt++;
            if (inv_done) dcnt++;
        end
        check_val("rstsweep_no_writes", 64'(wcnt), 64'd0);
        check_val("rstsweep_no_done", 64'(dcnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
